usb_ep_data_buffer: RTL and testbench
=====================================

# usb_ep_data_buffer

Parametrised, multi-endpoint successor to the single-endpoint USB data buffer. Sits between the USB RX/TX engines (byte-wide, one endpoint selected at a time) and the AHB-Lite slave (1/2/4-byte accesses, endpoint chosen by register). It keeps an independent circular byte FIFO per endpoint with per-endpoint occupancy, flush and clear, and error pulses on each side.

## Interface
- NUM_EP, 2, number of endpoint FIFOs (≥1); EPW = max(1,$clog2(NUM_EP))
- DEPTH, 64, bytes per endpoint FIFO (power of 2, ≥4); OCC_W = $clog2(DEPTH)+1
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  asynchronous active-low reset
- usb_ep_sel  in  EPW  endpoint addressed by USB-side strobes
- store_rx_data  in  1  push rx_packet_data into usb_ep_sel FIFO
- rx_packet_data  in  8  byte from receiver
- get_tx_data  in  1  pop head byte of usb_ep_sel FIFO
- tx_packet_data  out  8  head byte of usb_ep_sel FIFO (show-ahead), 8'h00 when empty
- flush  in  1  empty usb_ep_sel FIFO
- usb_error  out  1  one-cycle pulse: USB overflow/underflow
- bus_ep_sel  in  EPW  endpoint addressed by AHB-side strobes
- store_tx_data  in  1  push tx_size bytes of tx_data
- tx_data  in  32  write data, little-endian, byte 0 = bits[7:0] pushed first
- tx_size  in  2  0=1 B, 1=2 B, 2=4 B, 3=illegal
- get_rx_data  in  1  pop rx_size bytes into rx_data
- rx_size  in  2  same encoding as tx_size
- rx_data  out  32  registered pop result, unused upper bytes zero
- clear  in  1  empty bus_ep_sel FIFO
- bus_error  out  1  one-cycle pulse: AHB overflow/underflow/illegal size/collision
- buffer_occupancy  out  NUM_EP*OCC_W  per-endpoint byte count, EP n at [n*OCC_W +: OCC_W]

## Operation
- Per EP: rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), occupancy 0..DEPTH. Storage NUM_EP*DEPTH bytes of flops, EP n region base n*DEPTH.
- Push of k bytes accepted only if occ+k ≤ DEPTH (pre-cycle occ); otherwise whole push dropped (no partial), error pulse on that side.
- Pop of k bytes accepted only if occ ≥ k; otherwise dropped, pointers unchanged, rx_data unchanged, error pulse. USB pop on empty: usb_error.
- Size 3 on any bus strobe: dropped, bus_error.
- Same-EP concurrency: one USB op and one bus op of opposite kind proceed together; occ_next = occ + pushed − popped; acceptance judged on pre-cycle occ only.
- Collision: USB and bus both push, or both pop, same EP same cycle → USB op performed, bus op dropped, bus_error.
- flush/clear: rd_ptr=wr_ptr=0, occ=0; overrides every push/pop on that EP in the same cycle (no error raised for the overridden ops). flush and clear on different EPs both act.
- Operations on distinct EPs fully independent.
- Reset: all pointers/occupancies 0, rx_data 0, usb_error 0, bus_error 0, tx_packet_data 8'h00. Storage contents not reset.

## Timing
- Push/pop/flush/clear commit on the strobe edge; buffer_occupancy updates the following cycle.
- tx_packet_data combinational from usb_ep_sel and current rd_ptr; after get_tx_data the next byte is visible the following cycle.
- rx_data valid the cycle after accepted get_rx_data, held until the next accepted pop.
- Push then pop of the same byte: earliest pop is the cycle after the push (no same-cycle bypass on empty).
- Error pulses registered: high exactly one cycle, the cycle after the offending request.
- Reset asserted mid-transfer: all state to reset values immediately, no completion of in-flight op.

## Structure
- Package usb_buf_pkg: size encoding constants SZ_BYTE/SZ_HALF/SZ_WORD, function size_bytes(size) returning 0 for illegal.
- Sub-module usb_ep_fifo_ctrl (pointers, occupancy, accept/error decisions for one EP), instantiated NUM_EP times via generate; top holds storage, EP muxing, collision arbitration, rx_data and error registers.

## Test plan
- Reset, NUM_EP=2, DEPTH=64: all occupancies 0, tx_packet_data 8'h00, no error pulses.
- Bus push tx_data=32'h44332211 size 2 to EP1 → occ1=4; USB pops 4 from EP1 → bytes 11,22,33,44 in order, occ1=0, EP0 untouched.
- Fill EP0 with 62 bytes, bus push size 2 → dropped, bus_error one cycle, occ0 stays 62; push size 1 → occ0=64.
- USB pushes 3 bytes AA,BB,CC to EP0; bus pop size 2 → rx_data=32'h0000BBAA next cycle; pop size 2 again → bus_error, rx_data unchanged.
- Same cycle on EP1 (occ1=5): USB store and bus pop size 1 → occ1=5; USB store and bus store → occ1=6, bus_error.
- Wrap: cycle 200 bytes through EP0 one in/one out → data order preserved across pointer wrap; flush with concurrent store → occ0=0, no usb_error.

Source files
------------

// File: rtl/usb_buf_pkg.sv
// Shared encodings for the multi-endpoint USB data buffer.
package usb_buf_pkg;

  // Bus-side transfer size encoding
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Number of bytes moved for a size code; 0 marks the illegal encoding
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/usb_ep_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for one endpoint FIFO.
// Accept/error decisions use the occupancy held at the start of the cycle;
// a clear wins over any push or pop and silences their errors.
module usb_ep_fifo_ctrl #(
  parameter  int DEPTH = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int OCC_W = PW + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr_i,
  input  logic             push_req_i,
  input  logic [2:0]       push_k_i,
  input  logic             pop_req_i,
  input  logic [2:0]       pop_k_i,
  output logic             push_ok_o,
  output logic             pop_ok_o,
  output logic             push_err_o,
  output logic             pop_err_o,
  output logic [PW-1:0]    rd_ptr_o,
  output logic [PW-1:0]    wr_ptr_o,
  output logic [OCC_W-1:0] occ_o
);

  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W:0]   push_sum_s;
  logic             push_fit_s, pop_fit_s;
  logic [2:0]       push_n_s, pop_n_s;

  // Judge push/pop against pre-cycle occupancy and compute the next pointers
  always_comb begin
    push_sum_s = (OCC_W+1)'(occ_q) + (OCC_W+1)'(push_k_i);
    push_fit_s = (push_sum_s <= (OCC_W+1)'(DEPTH));
    pop_fit_s  = (occ_q >= OCC_W'(pop_k_i));
    push_ok_o  = push_req_i && push_fit_s && !clr_i;
    pop_ok_o   = pop_req_i && pop_fit_s && !clr_i;
    push_err_o = push_req_i && !push_fit_s && !clr_i;
    pop_err_o  = pop_req_i && !pop_fit_s && !clr_i;
    push_n_s   = push_ok_o ? push_k_i : 3'd0;
    pop_n_s    = pop_ok_o ? pop_k_i : 3'd0;
    if (clr_i) begin
      rd_d  = {PW{1'b0}};
      wr_d  = {PW{1'b0}};
      occ_d = {OCC_W{1'b0}};
    end else begin
      rd_d  = rd_q + PW'(pop_n_s);
      wr_d  = wr_q + PW'(push_n_s);
      occ_d = occ_q + OCC_W'(push_n_s) - OCC_W'(pop_n_s);
    end
  end

  // Pointer and occupancy state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_q  <= {PW{1'b0}};
      wr_q  <= {PW{1'b0}};
      occ_q <= {OCC_W{1'b0}};
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      occ_q <= occ_d;
    end
  end

  assign rd_ptr_o = rd_q;
  assign wr_ptr_o = wr_q;
  assign occ_o    = occ_q;

endmodule

// File: rtl/usb_ep_data_buffer.sv
// Multi-endpoint byte FIFO between the USB RX/TX engines and the AHB slave.
// Holds the byte storage, per-endpoint strobe routing, same-EP collision
// arbitration (USB side wins), the registered bus read data and error pulses.
module usb_ep_data_buffer
  import usb_buf_pkg::*;
#(
  parameter  int NUM_EP = 2,
  parameter  int DEPTH  = 64,
  localparam int EPW    = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
  localparam int PW     = $clog2(DEPTH),
  localparam int OCC_W  = PW + 1,
  localparam int AW     = (NUM_EP > 1) ? $clog2(NUM_EP * DEPTH) : PW
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [EPW-1:0]          usb_ep_sel,
  input  logic                    store_rx_data,
  input  logic [7:0]              rx_packet_data,
  input  logic                    get_tx_data,
  output logic [7:0]              tx_packet_data,
  input  logic                    flush,
  output logic                    usb_error,
  input  logic [EPW-1:0]          bus_ep_sel,
  input  logic                    store_tx_data,
  input  logic [31:0]             tx_data,
  input  logic [1:0]              tx_size,
  input  logic                    get_rx_data,
  input  logic [1:0]              rx_size,
  output logic [31:0]             rx_data,
  input  logic                    clear,
  output logic                    bus_error,
  output logic [NUM_EP*OCC_W-1:0] buffer_occupancy
);

  logic [7:0]       mem_q [NUM_EP*DEPTH];
  logic [2:0]       bus_tx_k_s, bus_rx_k_s;
  logic             tx_illegal_s, rx_illegal_s;
  logic [NUM_EP-1:0] usb_hit_s, bus_hit_s, usb_push_s, usb_pop_s;
  logic [NUM_EP-1:0] bus_push_s, bus_pop_s, push_coll_s, pop_coll_s;
  logic [NUM_EP-1:0] clr_s, push_req_s, pop_req_s;
  logic [NUM_EP-1:0] push_ok_s, pop_ok_s, push_err_s, pop_err_s;
  logic [2:0]       push_k_s [NUM_EP];
  logic [2:0]       pop_k_s  [NUM_EP];
  logic [PW-1:0]    rd_ptr_s [NUM_EP];
  logic [PW-1:0]    wr_ptr_s [NUM_EP];
  logic [OCC_W-1:0] occ_s    [NUM_EP];
  logic [7:0]       head_s   [NUM_EP];
  logic [31:0]      pop_word_s [NUM_EP];
  logic [31:0]      rx_data_q, rx_data_d;
  logic             usb_error_q, usb_error_d, bus_error_q, bus_error_d;

  // Flat storage address of byte 'off' past 'ptr' in endpoint 'ep', wrapping in its region
  function automatic logic [AW-1:0] addr(input int ep, input logic [PW-1:0] ptr, input int off);
    logic [PW-1:0] p;
    p = ptr + PW'(off);
    return AW'(ep * DEPTH) + AW'(p);
  endfunction

  // Decode strobes into per-endpoint requests; a same-kind bus op loses to USB
  always_comb begin
    bus_tx_k_s   = size_bytes(tx_size);
    bus_rx_k_s   = size_bytes(rx_size);
    tx_illegal_s = store_tx_data && (bus_tx_k_s == 3'd0);
    rx_illegal_s = get_rx_data && (bus_rx_k_s == 3'd0);
    usb_hit_s = {NUM_EP{1'b0}};  bus_hit_s = {NUM_EP{1'b0}};
    usb_push_s = {NUM_EP{1'b0}}; usb_pop_s = {NUM_EP{1'b0}};
    bus_push_s = {NUM_EP{1'b0}}; bus_pop_s = {NUM_EP{1'b0}};
    push_coll_s = {NUM_EP{1'b0}}; pop_coll_s = {NUM_EP{1'b0}};
    clr_s = {NUM_EP{1'b0}}; push_req_s = {NUM_EP{1'b0}}; pop_req_s = {NUM_EP{1'b0}};
    for (int e = 0; e < NUM_EP; e++) begin
      usb_hit_s[e]   = (int'(usb_ep_sel) == e);
      bus_hit_s[e]   = (int'(bus_ep_sel) == e);
      usb_push_s[e]  = store_rx_data && usb_hit_s[e];
      usb_pop_s[e]   = get_tx_data && usb_hit_s[e];
      push_coll_s[e] = store_tx_data && !tx_illegal_s && bus_hit_s[e] && usb_push_s[e];
      pop_coll_s[e]  = get_rx_data && !rx_illegal_s && bus_hit_s[e] && usb_pop_s[e];
      bus_push_s[e]  = store_tx_data && !tx_illegal_s && bus_hit_s[e] && !usb_push_s[e];
      bus_pop_s[e]   = get_rx_data && !rx_illegal_s && bus_hit_s[e] && !usb_pop_s[e];
      clr_s[e]       = (flush && usb_hit_s[e]) || (clear && bus_hit_s[e]);
      push_req_s[e]  = usb_push_s[e] || bus_push_s[e];
      pop_req_s[e]   = usb_pop_s[e] || bus_pop_s[e];
      push_k_s[e]    = usb_push_s[e] ? 3'd1 : bus_tx_k_s;
      pop_k_s[e]     = usb_pop_s[e] ? 3'd1 : bus_rx_k_s;
    end
  end

  for (genvar g = 0; g < NUM_EP; g++) begin : g_ep
    usb_ep_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk       (clk),
      .n_rst     (n_rst),
      .clr_i     (clr_s[g]),
      .push_req_i(push_req_s[g]),
      .push_k_i  (push_k_s[g]),
      .pop_req_i (pop_req_s[g]),
      .pop_k_i   (pop_k_s[g]),
      .push_ok_o (push_ok_s[g]),
      .pop_ok_o  (pop_ok_s[g]),
      .push_err_o(push_err_s[g]),
      .pop_err_o (pop_err_s[g]),
      .rd_ptr_o  (rd_ptr_s[g]),
      .wr_ptr_o  (wr_ptr_s[g]),
      .occ_o     (occ_s[g])
    );
    assign buffer_occupancy[g*OCC_W +: OCC_W] = occ_s[g];
  end

  // Byte storage: accepted pushes write little-endian from the write pointer (not reset)
  always_ff @(posedge clk) begin
    for (int e = 0; e < NUM_EP; e++) begin
      if (push_ok_s[e]) begin
        if (usb_push_s[e]) begin
          mem_q[addr(e, wr_ptr_s[e], 0)] <= rx_packet_data;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (i < int'(push_k_s[e])) mem_q[addr(e, wr_ptr_s[e], i)] <= tx_data[8*i +: 8];
          end
        end
      end
    end
  end

  // Per-endpoint show-ahead byte and candidate bus pop word (unused bytes zero)
  always_comb begin
    for (int e = 0; e < NUM_EP; e++) begin
      head_s[e] = (occ_s[e] != {OCC_W{1'b0}}) ? mem_q[addr(e, rd_ptr_s[e], 0)] : 8'h00;
      for (int i = 0; i < 4; i++) begin
        pop_word_s[e][8*i +: 8] = (i < int'(pop_k_s[e])) ? mem_q[addr(e, rd_ptr_s[e], i)] : 8'h00;
      end
    end
  end

  // Output muxing, next bus read data and error pulse conditions
  always_comb begin
    if (int'(usb_ep_sel) < NUM_EP) begin
      tx_packet_data = head_s[usb_ep_sel];
    end else begin
      tx_packet_data = 8'h00;
    end
    if (|(bus_pop_s & pop_ok_s)) begin
      rx_data_d = pop_word_s[bus_ep_sel];
    end else begin
      rx_data_d = rx_data_q;
    end
    usb_error_d = |((usb_push_s & push_err_s) | (usb_pop_s & pop_err_s));
    bus_error_d = tx_illegal_s || rx_illegal_s ||
                  (|((bus_push_s & push_err_s) | (bus_pop_s & pop_err_s) |
                     ((push_coll_s | pop_coll_s) & ~clr_s)));
  end

  // Registered bus read data and one-cycle error pulses
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data_q   <= 32'h0000_0000;
      usb_error_q <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      usb_error_q <= usb_error_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign usb_error = usb_error_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_usb_ep_data_buffer.sv
// Bench for usb_ep_data_buffer: directed scenarios plus random traffic,
// checked against per-endpoint byte queues.
module tb_usb_ep_data_buffer;

  localparam int NUM_EP = 2;
  localparam int DEPTH  = 64;
  localparam int EPW    = 1;
  localparam int OCC_W  = 7;

  logic                    clk = 1'b0;
  logic                    n_rst;
  logic [EPW-1:0]          usb_ep_sel;
  logic                    store_rx_data;
  logic [7:0]              rx_packet_data;
  logic                    get_tx_data;
  logic [7:0]              tx_packet_data;
  logic                    flush;
  logic                    usb_error;
  logic [EPW-1:0]          bus_ep_sel;
  logic                    store_tx_data;
  logic [31:0]             tx_data;
  logic [1:0]              tx_size;
  logic                    get_rx_data;
  logic [1:0]              rx_size;
  logic [31:0]             rx_data;
  logic                    clear;
  logic                    bus_error;
  logic [NUM_EP*OCC_W-1:0] buffer_occupancy;

  usb_ep_data_buffer #(.NUM_EP(NUM_EP), .DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .usb_ep_sel(usb_ep_sel), .store_rx_data(store_rx_data),
    .rx_packet_data(rx_packet_data), .get_tx_data(get_tx_data), .tx_packet_data(tx_packet_data),
    .flush(flush), .usb_error(usb_error), .bus_ep_sel(bus_ep_sel), .store_tx_data(store_tx_data),
    .tx_data(tx_data), .tx_size(tx_size), .get_rx_data(get_rx_data), .rx_size(rx_size),
    .rx_data(rx_data), .clear(clear), .bus_error(bus_error), .buffer_occupancy(buffer_occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one byte queue per endpoint
  logic [7:0]  q [NUM_EP][$];
  logic [31:0] m_rx;
  logic        exp_uerr, exp_berr;

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int dut_occ(input int e);
    return int'(buffer_occupancy[e*OCC_W +: OCC_W]);
  endfunction

  function automatic logic [7:0] m_head(input int e);
    if (q[e].size() > 0) return q[e][0];
    return 8'h00;
  endfunction

  task automatic idle();
    store_rx_data = 1'b0; get_tx_data = 1'b0; flush = 1'b0;
    store_tx_data = 1'b0; get_rx_data = 1'b0; clear = 1'b0;
  endtask

  task automatic model_reset();
    for (int e = 0; e < NUM_EP; e++) q[e].delete();
    m_rx = 32'h0; exp_uerr = 1'b0; exp_berr = 1'b0;
  endtask

  // Apply one cycle of the current strobes to the queues
  task automatic model_apply();
    int kt, kr, ue, be;
    int pre [NUM_EP];
    bit clr [NUM_EP];
    bit u_push, u_pop, b_push, b_pop;
    kt = nbytes(tx_size); kr = nbytes(rx_size);
    ue = int'(usb_ep_sel); be = int'(bus_ep_sel);
    for (int e = 0; e < NUM_EP; e++) begin
      pre[e] = q[e].size();
      clr[e] = (flush && ue == e) || (clear && be == e);
    end
    exp_uerr = 1'b0; exp_berr = 1'b0;
    u_push = store_rx_data; u_pop = get_tx_data;
    b_push = store_tx_data && kt != 0;
    b_pop  = get_rx_data && kr != 0;
    if (store_tx_data && kt == 0) exp_berr = 1'b1;
    if (get_rx_data && kr == 0) exp_berr = 1'b1;
    if (b_push && u_push && be == ue) begin
      if (!clr[be]) exp_berr = 1'b1;
      b_push = 1'b0;
    end
    if (b_pop && u_pop && be == ue) begin
      if (!clr[be]) exp_berr = 1'b1;
      b_pop = 1'b0;
    end
    if (u_push && clr[ue]) u_push = 1'b0;
    if (u_pop && clr[ue]) u_pop = 1'b0;
    if (b_push && clr[be]) b_push = 1'b0;
    if (b_pop && clr[be]) b_pop = 1'b0;
    if (u_push && pre[ue] + 1 > DEPTH) begin exp_uerr = 1'b1; u_push = 1'b0; end
    if (u_pop && pre[ue] < 1) begin exp_uerr = 1'b1; u_pop = 1'b0; end
    if (b_push && pre[be] + kt > DEPTH) begin exp_berr = 1'b1; b_push = 1'b0; end
    if (b_pop && pre[be] < kr) begin exp_berr = 1'b1; b_pop = 1'b0; end
    if (u_pop) void'(q[ue].pop_front());
    if (b_pop) begin
      m_rx = 32'h0;
      for (int i = 0; i < kr; i++) m_rx[8*i +: 8] = q[be].pop_front();
    end
    if (u_push) q[ue].push_back(rx_packet_data);
    if (b_push) for (int i = 0; i < kt; i++) q[be].push_back(tx_data[8*i +: 8]);
    for (int e = 0; e < NUM_EP; e++) if (clr[e]) q[e].delete();
  endtask

  // One clock: update model, take the edge, sample 1 time unit later, drop strobes
  task automatic cyc();
    model_apply();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    n_rst = 1'b0; idle();
    usb_ep_sel = 1'b0; bus_ep_sel = 1'b0; rx_packet_data = 8'h00;
    tx_data = 32'h0; tx_size = 2'd0; rx_size = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int e = 0; e < NUM_EP; e++) begin
      checks++;
      if (dut_occ(e) !== 0) begin errors++; $display("FAIL reset_occ%0d: got %0d expected 0", e, dut_occ(e)); end
    end
    checks++;
    if (tx_packet_data !== 8'h00) begin errors++; $display("FAIL reset_tx: got %h expected 00", tx_packet_data); end
    checks++;
    if (rx_data !== 32'h0) begin errors++; $display("FAIL reset_rx: got %h expected 0", rx_data); end
    checks++;
    if (usb_error !== 1'b0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b%b expected 00", usb_error, bus_error);
    end
    n_rst = 1'b1;
    cyc();
    checks++;
    if (usb_error !== 1'b0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL idle_err: got %b%b expected 00", usb_error, bus_error);
    end
  endtask

  task automatic test_bus_push_usb_pop();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    usb_ep_sel = 1'b0; store_rx_data = 1'b1; rx_packet_data = 8'h5A; cyc();
    bus_ep_sel = 1'b1; store_tx_data = 1'b1; tx_data = 32'h44332211; tx_size = 2'd2; cyc();
    checks++;
    if (dut_occ(1) !== 4) begin errors++; $display("FAIL word_push_occ1: got %0d expected 4", dut_occ(1)); end
    for (int i = 0; i < 4; i++) begin
      usb_ep_sel = 1'b1; get_tx_data = 1'b1; #1;
      checks++;
      if (tx_packet_data !== exp_b[i]) begin
        errors++; $display("FAIL usb_pop_byte%0d: got %h expected %h", i, tx_packet_data, exp_b[i]);
      end
      cyc();
    end
    checks++;
    if (dut_occ(1) !== 0 || dut_occ(0) !== 1) begin
      errors++; $display("FAIL after_pop_occ: got %0d/%0d expected 1/0", dut_occ(0), dut_occ(1));
    end
    usb_ep_sel = 1'b0; #1;
    checks++;
    if (tx_packet_data !== 8'h5A) begin errors++; $display("FAIL ep0_untouched: got %h expected 5a", tx_packet_data); end
    flush = 1'b1; cyc();
    checks++;
    if (dut_occ(0) !== 0 || usb_error !== 1'b0) begin
      errors++; $display("FAIL flush_ep0: got occ %0d err %b expected 0 0", dut_occ(0), usb_error);
    end
  endtask

  task automatic test_overflow();
    bus_ep_sel = 1'b0;
    for (int i = 0; i < 15; i++) begin
      store_tx_data = 1'b1; tx_data = $urandom; tx_size = 2'd2; cyc();
    end
    store_tx_data = 1'b1; tx_data = $urandom; tx_size = 2'd1; cyc();
    checks++;
    if (dut_occ(0) !== 62) begin errors++; $display("FAIL fill_occ0: got %0d expected 62", dut_occ(0)); end
    store_tx_data = 1'b1; tx_data = $urandom; tx_size = 2'd2; cyc();
    checks++;
    if (bus_error !== 1'b1 || dut_occ(0) !== 62) begin
      errors++; $display("FAIL overflow_drop: got err %b occ %0d expected 1 62", bus_error, dut_occ(0));
    end
    cyc();
    checks++;
    if (bus_error !== 1'b0) begin errors++; $display("FAIL overflow_pulse_len: got %b expected 0", bus_error); end
    store_tx_data = 1'b1; tx_data = $urandom; tx_size = 2'd1; cyc();
    checks++;
    if (bus_error !== 1'b0 || dut_occ(0) !== 64) begin
      errors++; $display("FAIL fill_to_full: got err %b occ %0d expected 0 64", bus_error, dut_occ(0));
    end
    usb_ep_sel = 1'b0; store_rx_data = 1'b1; rx_packet_data = 8'hEE; cyc();
    checks++;
    if (usb_error !== 1'b1 || dut_occ(0) !== 64) begin
      errors++; $display("FAIL usb_overflow: got err %b occ %0d expected 1 64", usb_error, dut_occ(0));
    end
    for (int i = 0; i < 16; i++) begin
      get_rx_data = 1'b1; rx_size = 2'd2; cyc();
      checks++;
      if (rx_data !== m_rx) begin errors++; $display("FAIL drain_word%0d: got %h expected %h", i, rx_data, m_rx); end
    end
    checks++;
    if (dut_occ(0) !== 0) begin errors++; $display("FAIL drain_occ0: got %0d expected 0", dut_occ(0)); end
  endtask

  task automatic test_underflow();
    logic [7:0] bytes_in [3];
    bytes_in[0] = 8'hAA; bytes_in[1] = 8'hBB; bytes_in[2] = 8'hCC;
    for (int i = 0; i < 3; i++) begin
      usb_ep_sel = 1'b0; store_rx_data = 1'b1; rx_packet_data = bytes_in[i]; cyc();
    end
    bus_ep_sel = 1'b0; get_rx_data = 1'b1; rx_size = 2'd1; cyc();
    checks++;
    if (rx_data !== 32'h0000BBAA || bus_error !== 1'b0) begin
      errors++; $display("FAIL half_pop: got %h err %b expected 0000bbaa 0", rx_data, bus_error);
    end
    get_rx_data = 1'b1; rx_size = 2'd1; cyc();
    checks++;
    if (rx_data !== 32'h0000BBAA || bus_error !== 1'b1 || dut_occ(0) !== 1) begin
      errors++; $display("FAIL half_underflow: got %h err %b occ %0d expected 0000bbaa 1 1", rx_data, bus_error, dut_occ(0));
    end
    get_tx_data = 1'b1; #1;
    checks++;
    if (tx_packet_data !== 8'hCC) begin errors++; $display("FAIL last_byte: got %h expected cc", tx_packet_data); end
    cyc();
    get_tx_data = 1'b1; #1;
    checks++;
    if (tx_packet_data !== 8'h00) begin errors++; $display("FAIL empty_tx: got %h expected 00", tx_packet_data); end
    cyc();
    checks++;
    if (usb_error !== 1'b1) begin errors++; $display("FAIL usb_underflow: got %b expected 1", usb_error); end
    get_rx_data = 1'b1; rx_size = 2'd3; cyc();
    checks++;
    if (bus_error !== 1'b1 || rx_data !== 32'h0000BBAA) begin
      errors++; $display("FAIL illegal_size: got err %b rx %h expected 1 0000bbaa", bus_error, rx_data);
    end
  endtask

  task automatic test_concurrency();
    usb_ep_sel = 1'b1; bus_ep_sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      store_rx_data = 1'b1; rx_packet_data = 8'($urandom); cyc();
    end
    store_rx_data = 1'b1; rx_packet_data = 8'h77; get_rx_data = 1'b1; rx_size = 2'd0; cyc();
    checks++;
    if (dut_occ(1) !== 5 || bus_error !== 1'b0 || usb_error !== 1'b0 || rx_data !== m_rx) begin
      errors++; $display("FAIL push_pop_same_ep: got occ %0d errs %b%b rx %h expected 5 00 %h",
                         dut_occ(1), usb_error, bus_error, rx_data, m_rx);
    end
    store_rx_data = 1'b1; rx_packet_data = 8'h88; store_tx_data = 1'b1; tx_data = 32'h99; tx_size = 2'd0; cyc();
    checks++;
    if (dut_occ(1) !== 6 || bus_error !== 1'b1 || usb_error !== 1'b0) begin
      errors++; $display("FAIL push_collision: got occ %0d errs %b%b expected 6 01", dut_occ(1), usb_error, bus_error);
    end
    for (int i = 0; i < 6; i++) begin
      get_tx_data = 1'b1; #1;
      checks++;
      if (tx_packet_data !== m_head(1)) begin
        errors++; $display("FAIL coll_data%0d: got %h expected %h", i, tx_packet_data, m_head(1));
      end
      cyc();
    end
    store_tx_data = 1'b1; tx_data = 32'h12345678; tx_size = 2'd2; clear = 1'b1; cyc();
    checks++;
    if (dut_occ(1) !== 0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL clear_override: got occ %0d err %b expected 0 0", dut_occ(1), bus_error);
    end
  endtask

  task automatic test_wrap_flush();
    logic [7:0] vals [200];
    for (int i = 0; i < 200; i++) vals[i] = 8'($urandom);
    usb_ep_sel = 1'b0; bus_ep_sel = 1'b0;
    store_tx_data = 1'b1; tx_data = {24'h0, vals[0]}; tx_size = 2'd0; cyc();
    for (int i = 1; i < 200; i++) begin
      store_tx_data = 1'b1; tx_data = {24'h0, vals[i]}; tx_size = 2'd0; get_tx_data = 1'b1; #1;
      checks++;
      if (tx_packet_data !== vals[i-1]) begin
        errors++; $display("FAIL wrap_byte%0d: got %h expected %h", i - 1, tx_packet_data, vals[i-1]);
      end
      cyc();
    end
    checks++;
    if (dut_occ(0) !== 1 || usb_error !== 1'b0) begin
      errors++; $display("FAIL wrap_occ: got %0d err %b expected 1 0", dut_occ(0), usb_error);
    end
    flush = 1'b1; store_rx_data = 1'b1; rx_packet_data = 8'h42; cyc();
    checks++;
    if (dut_occ(0) !== 0 || usb_error !== 1'b0) begin
      errors++; $display("FAIL flush_store: got occ %0d err %b expected 0 0", dut_occ(0), usb_error);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      usb_ep_sel     = EPW'($urandom_range(0, NUM_EP - 1));
      bus_ep_sel     = EPW'($urandom_range(0, NUM_EP - 1));
      store_rx_data  = ($urandom_range(0, 99) < 40);
      get_tx_data    = ($urandom_range(0, 99) < 35);
      flush          = ($urandom_range(0, 99) < 2);
      store_tx_data  = ($urandom_range(0, 99) < 30);
      get_rx_data    = ($urandom_range(0, 99) < 30);
      clear          = ($urandom_range(0, 99) < 2);
      rx_packet_data = 8'($urandom);
      tx_data        = $urandom;
      tx_size        = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rx_size        = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      #1;
      checks++;
      if (tx_packet_data !== m_head(int'(usb_ep_sel))) begin
        errors++; $display("FAIL rnd_tx cyc%0d: got %h expected %h", n, tx_packet_data, m_head(int'(usb_ep_sel)));
      end
      cyc();
      for (int e = 0; e < NUM_EP; e++) begin
        checks++;
        if (dut_occ(e) !== q[e].size()) begin
          errors++; $display("FAIL rnd_occ%0d cyc%0d: got %0d expected %0d", e, n, dut_occ(e), q[e].size());
        end
      end
      checks++;
      if (rx_data !== m_rx) begin errors++; $display("FAIL rnd_rx cyc%0d: got %h expected %h", n, rx_data, m_rx); end
      checks++;
      if (usb_error !== exp_uerr || bus_error !== exp_berr) begin
        errors++; $display("FAIL rnd_err cyc%0d: got %b%b expected %b%b", n, usb_error, bus_error, exp_uerr, exp_berr);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus_ep_sel = 1'b1; store_tx_data = 1'b1; tx_data = $urandom; tx_size = 2'd2; cyc();
    get_rx_data = 1'b1; rx_size = 2'd1; store_tx_data = 1'b1; tx_size = 2'd2; #2;
    n_rst = 1'b0; #1;
    checks++;
    if (dut_occ(0) !== 0 || dut_occ(1) !== 0 || rx_data !== 32'h0 || tx_packet_data !== 8'h00) begin
      errors++; $display("FAIL mid_reset: got occ %0d/%0d rx %h tx %h expected zeros",
                         dut_occ(0), dut_occ(1), rx_data, tx_packet_data);
    end
    @(posedge clk); #1;
    checks++;
    if (dut_occ(1) !== 0 || usb_error !== 1'b0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL held_reset: got occ %0d errs %b%b expected 0 00", dut_occ(1), usb_error, bus_error);
    end
    idle(); model_reset(); n_rst = 1'b1;
    cyc();
    checks++;
    if (dut_occ(1) !== 0 || rx_data !== 32'h0) begin
      errors++; $display("FAIL after_reset: got occ %0d rx %h expected 0 0", dut_occ(1), rx_data);
    end
  endtask

  initial begin
    test_reset();
    test_bus_push_usb_pop();
    test_overflow();
    test_underflow();
    test_concurrency();
    test_wrap_flush();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
